// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host frame receiver with glitch filter, timeout and inhibit
module ps2_frame_rx #(
    parameter int CLK_FREQ   = 28000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000,
    parameter int INHIBIT_US = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out,
    output logic [7:0] dataout,
    output logic       dataout_valid,
    output logic       dataout_error
);
    localparam longint TMO_CYC = (longint'(TIMEOUT_US) * longint'(CLK_FREQ)) / 64'd1000000;
    localparam longint INH_CYC = (longint'(INHIBIT_US) * longint'(CLK_FREQ)) / 64'd1000000;
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam int IW = $clog2(INH_CYC + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(TMO_CYC);
    localparam logic [IW-1:0] INH_LAST = IW'(INH_CYC - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_INHIBIT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    meta_q, meta_d, sync_q, sync_d;
    logic          fclk_q, fclk_d;
    logic [FW-1:0] flt_q, flt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [7:0]    dataout_q, dataout_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [IW-1:0] inh_q, inh_d;
    logic          strobe, dat_s, active;

    // sync bit 1 carries the clock line, bit 0 the data line
    always_comb begin
        meta_d = {ps2_clk_in, ps2_dat_in};
        sync_d = meta_q;
        fclk_d = fclk_q;
        flt_d  = '0;
        if (sync_q[1] != fclk_q) begin
            if (flt_q == FLT_LAST) begin
                fclk_d = sync_q[1];
            end else begin
                flt_d = flt_q + 1'b1;
            end
        end
        strobe = fclk_q & ~fclk_d;
        dat_s  = sync_q[0];
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        dataout_d = dataout_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        inh_d     = '0;
        active    = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);

        if (!active || strobe) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_LIM) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end

        case (state_q)
            S_IDLE: begin
                if (strobe && !dat_s) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                end
            end
            S_DATA: begin
                if (strobe) begin
                    shreg_d  = {dat_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (strobe) begin
                    parity_d = dat_s;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (strobe) begin
                    if (dat_s && (^{shreg_q, parity_q})) begin
                        dataout_d = shreg_q;
                        valid_d   = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_INHIBIT;
                    end
                end
            end
            S_INHIBIT: begin
                inh_d = inh_q + 1'b1;
                if (inh_q == INH_LAST) begin
                    inh_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a strobe landing on the expiry cycle takes priority over the timeout
        if (active && !strobe && (tmo_q >= TMO_LIM - 1'b1)) begin
            error_d = 1'b1;
            state_d = S_INHIBIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            meta_q    <= 2'b11;
            sync_q    <= 2'b11;
            fclk_q    <= 1'b1;
            flt_q     <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            dataout_q <= 8'h00;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            tmo_q     <= '0;
            inh_q     <= '0;
        end else begin
            state_q   <= state_d;
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            fclk_q    <= fclk_d;
            flt_q     <= flt_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            tmo_q     <= tmo_d;
            inh_q     <= inh_d;
        end
    end

    assign ps2_clk_out   = (state_q != S_INHIBIT);
    assign ps2_dat_out   = 1'b1;
    assign dataout       = dataout_q;
    assign dataout_valid = valid_q;
    assign dataout_error = error_q;
endmodule
